// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2
  } state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned TIMEOUT_W        = 8;

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v,
                                                   input logic [TIMEOUT_W-1:0] lim);
    return (v >= lim) ? lim : v + TIMEOUT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Handshake bundle between the fetch controller, the I-cache front port and decode/hazard.
interface fetch_pc_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;
  logic            Stall;
  logic            IC_Ready;
  logic            IC_Req;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCNext;
  logic            PCEn;
  logic            FetchValid;
  logic            Timeout;

  modport slave (
    input  Redirect, RedirectPC, Stall, IC_Ready,
    output IC_Req, PC, PCNext, PCEn, FetchValid, Timeout
  );

  modport master (
    output Redirect, RedirectPC, Stall, IC_Ready,
    input  IC_Req, PC, PCNext, PCEn, FetchValid, Timeout
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter register with load enable and asynchronous reset to the boot address.
module pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage controller: sequences the PC against the I-cache handshake, holding on misses
// and stalls, and deferring redirects that arrive while a miss is outstanding.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     TIMEOUT  = 255
) (
  input logic            CLK,
  input logic            RST,
  fetch_pc_ctrl_if.slave bus
);

  localparam logic [TIMEOUT_W-1:0] TimeoutLim = TIMEOUT_W'(TIMEOUT);
  localparam logic [XLEN-1:0]      AlignMask  = ~XLEN'(INSTR_BYTES - 1);

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [XLEN-1:0]        pend_pc_q, pend_pc_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic [XLEN-1:0]        pc, pc_next, pc_inc, redir_pc;
  logic                   pc_en, ic_req, fetch_valid;

  assign redir_pc = bus.RedirectPC & AlignMask;
  assign pc_inc   = pc + XLEN'(INSTR_BYTES);

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk (CLK),
    .rst (RST),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= BOOT;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    ic_req      = 1'b0;
    pc_en       = 1'b0;
    pc_next     = pc;
    fetch_valid = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        ic_req = 1'b1;
        if (bus.Redirect) begin
          pc_en   = 1'b1;
          pc_next = redir_pc;
        end else if (bus.IC_Ready) begin
          fetch_valid = 1'b1;
          if (!bus.Stall) begin
            pc_en   = 1'b1;
            pc_next = pc_inc;
          end
        end else begin
          state_d = MISS;
          cnt_d   = TIMEOUT_W'(1);
          if (TimeoutLim <= TIMEOUT_W'(1)) timeout_d = 1'b1;
        end
      end

      MISS: begin
        ic_req = 1'b1;
        if (bus.IC_Ready) begin
          state_d = FETCH;
          cnt_d   = '0;
          pend_d  = 1'b0;
          // A same-cycle redirect is newer than anything captured during the miss.
          if (bus.Redirect || pend_q) begin
            pc_en   = 1'b1;
            pc_next = bus.Redirect ? redir_pc : pend_pc_q;
          end else begin
            fetch_valid = 1'b1;
            if (!bus.Stall) begin
              pc_en   = 1'b1;
              pc_next = pc_inc;
            end
          end
        end else begin
          if (bus.Redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_pc;
          end
          cnt_d = sat_inc(cnt_q, TimeoutLim);
          if (cnt_d == TimeoutLim) timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.IC_Req     = ic_req;
  assign bus.PC         = pc;
  assign bus.PCNext     = pc_next;
  assign bus.PCEn       = pc_en;
  assign bus.FetchValid = fetch_valid;
  assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model of the fetch sequencing rules.
module tb_fetch_pc_ctrl;

  localparam int unsigned    TIMEOUT  = 255;
  localparam logic [31:0]    RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.XLEN(32)) bus ();

  fetch_pc_ctrl #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Reference model: "in a miss" flag, redirects seen during the miss, miss length.
  logic [31:0] m_pc;
  bit          m_in_miss;
  logic [31:0] m_miss_redirects[$];
  int          m_miss_len;
  bit          m_timeout;

  logic [31:0] exp_pc, exp_next;
  logic        exp_req, exp_en, exp_fv, exp_to;
  logic [31:0] obs_pc, obs_next;
  logic        obs_req, obs_en, obs_fv, obs_to;

  task automatic reset_model();
    m_pc       = RESET_PC;
    m_in_miss  = 0;
    m_miss_redirects.delete();
    m_miss_len = 0;
    m_timeout  = 0;
  endtask

  task automatic model_step(input logic rdir, input logic [31:0] rpc, input logic stall,
                            input logic rdy);
    logic [31:0] tgt;
    exp_req  = 1'b1;
    exp_pc   = m_pc;
    exp_to   = m_timeout;
    exp_en   = 1'b0;
    exp_fv   = 1'b0;
    exp_next = m_pc;
    tgt      = {rpc[31:2], 2'b00};
    if (rdy && (rdir || (m_in_miss && m_miss_redirects.size() > 0))) begin
      exp_en   = 1'b1;
      exp_next = rdir ? tgt : m_miss_redirects[$];
    end else if (rdir && !m_in_miss) begin
      exp_en   = 1'b1;
      exp_next = tgt;
    end else if (rdy) begin
      exp_fv = 1'b1;
      if (!stall) begin
        exp_en   = 1'b1;
        exp_next = m_pc + 32'd4;
      end
    end
    if (rdy) begin
      m_in_miss  = 0;
      m_miss_len = 0;
      m_miss_redirects.delete();
    end else if (m_in_miss || !rdir) begin
      if (m_in_miss && rdir) m_miss_redirects.push_back(tgt);
      m_in_miss  = 1;
      m_miss_len = m_miss_len + 1;
      if (m_miss_len >= int'(TIMEOUT)) m_timeout = 1;
    end
    if (exp_en) m_pc = exp_next;
  endtask

  task automatic tick(input logic rdir, input logic [31:0] rpc, input logic stall,
                      input logic rdy);
    @(negedge clk);
    bus.Redirect   = rdir;
    bus.RedirectPC = rpc;
    bus.Stall      = stall;
    bus.IC_Ready   = rdy;
    #1;
    obs_pc   = bus.PC;
    obs_next = bus.PCNext;
    obs_req  = bus.IC_Req;
    obs_en   = bus.PCEn;
    obs_fv   = bus.FetchValid;
    obs_to   = bus.Timeout;
    model_step(rdir, rpc, stall, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Stall = 1'b0; bus.IC_Ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Stall = 1'b0; bus.IC_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (bus.PC !== RESET_PC || bus.IC_Req !== 1'b0 || bus.Timeout !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: pc=%h req=%b to=%b expected pc=%h req=0 to=0",
                 bus.PC, bus.IC_Req, bus.Timeout, RESET_PC);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    total++;
    if (bus.IC_Req !== 1'b0 || bus.PCEn !== 1'b0 || bus.FetchValid !== 1'b0) begin
      bad++;
      $display("FAIL boot_cycle: req=%b en=%b fv=%b expected 0 0 0",
               bus.IC_Req, bus.PCEn, bus.FetchValid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (obs_pc !== 32'(4 * i) || obs_req !== 1'b1 || obs_fv !== 1'b1) begin
        bad++;
        $display("FAIL hit_stream[%0d]: pc=%h req=%b fv=%b expected pc=%h req=1 fv=1",
                 i, obs_pc, obs_req, obs_fv, 32'(4 * i));
      end
    end
  endtask

  task automatic test_miss_then_hit();
    do_reset();
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (obs_pc !== 32'h8 || obs_fv !== 1'b0 || obs_en !== 1'b0 || obs_req !== 1'b1) begin
        bad++;
        $display("FAIL miss_hold[%0d]: pc=%h fv=%b en=%b req=%b expected pc=8 fv=0 en=0 req=1",
                 i, obs_pc, obs_fv, obs_en, obs_req);
      end
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_fv !== 1'b1 || obs_en !== 1'b1 || obs_next !== 32'hC) begin
      bad++;
      $display("FAIL miss_return: fv=%b en=%b next=%h expected fv=1 en=1 next=c",
               obs_fv, obs_en, obs_next);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_pc !== 32'hC) begin
      bad++;
      $display("FAIL miss_advance: pc=%h expected c", obs_pc);
    end
  endtask

  task automatic test_redirect_in_miss();
    do_reset();
    repeat (4) tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h103, 1'b0, 1'b0);
    total++;
    if (obs_pc !== 32'h10 || obs_en !== 1'b0) begin
      bad++;
      $display("FAIL miss_redirect_held: pc=%h en=%b expected pc=10 en=0", obs_pc, obs_en);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h200, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    total++;
    if (obs_fv !== 1'b0 || obs_en !== 1'b1 || obs_next !== 32'h200) begin
      bad++;
      $display("FAIL miss_redirect_apply: fv=%b en=%b next=%h expected fv=0 en=1 next=200",
               obs_fv, obs_en, obs_next);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_pc !== 32'h200) begin
      bad++;
      $display("FAIL miss_redirect_pc: pc=%h expected 200", obs_pc);
    end
  endtask

  task automatic test_stall_vs_redirect();
    do_reset();
    tick(1'b1, 32'h20, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      total++;
      if (obs_pc !== 32'h20 || obs_fv !== 1'b1 || obs_en !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: pc=%h fv=%b en=%b expected pc=20 fv=1 en=0",
                 i, obs_pc, obs_fv, obs_en);
      end
    end
    tick(1'b1, 32'h40, 1'b1, 1'b1);
    total++;
    if (obs_fv !== 1'b0 || obs_next !== 32'h40) begin
      bad++;
      $display("FAIL stall_redirect: fv=%b next=%h expected fv=0 next=40", obs_fv, obs_next);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    total++;
    if (obs_pc !== 32'h40) begin
      bad++;
      $display("FAIL stall_redirect_pc: pc=%h expected 40", obs_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_pc !== 32'hFFFF_FFFC || obs_next !== 32'h0 || obs_en !== 1'b1) begin
      bad++;
      $display("FAIL wrap_next: pc=%h next=%h en=%b expected pc=fffffffc next=0 en=1",
               obs_pc, obs_next, obs_en);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_pc !== 32'h0) begin
      bad++;
      $display("FAIL wrap_pc: pc=%h expected 0", obs_pc);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      if (i == int'(TIMEOUT)) begin
        total++;
        if (obs_to !== 1'b0) begin
          bad++;
          $display("FAIL timeout_early: to=%b expected 0", obs_to);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (obs_to !== 1'b1 || obs_to !== exp_to) begin
        bad++;
        $display("FAIL timeout_sticky[%0d]: to=%b expected 1", i, obs_to);
      end
    end
  endtask

  // Runs straight after test_timeout so Timeout is set when reset hits.
  task automatic test_async_reset();
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.PC !== RESET_PC || bus.IC_Req !== 1'b0 || bus.Timeout !== 1'b0 ||
        bus.PCEn !== 1'b0 || bus.FetchValid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: pc=%h req=%b to=%b en=%b fv=%b expected pc=%h 0 0 0 0",
               bus.PC, bus.IC_Req, bus.Timeout, bus.PCEn, bus.FetchValid, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs_pc !== RESET_PC || obs_req !== 1'b1 || obs_to !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_resume: pc=%h req=%b to=%b expected pc=%h req=1 to=0",
               obs_pc, obs_req, obs_to, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        rdir, stall, rdy;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdir  = ($urandom_range(0, 5) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      stall = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      tick(rdir, rpc, stall, rdy);
      total++;
      if (obs_pc !== exp_pc || obs_next !== exp_next || obs_en !== exp_en ||
          obs_fv !== exp_fv || obs_req !== exp_req || obs_to !== exp_to) begin
        bad++;
        $display("FAIL random[%0d]: pc=%h next=%h en=%b fv=%b req=%b to=%b expected %h %h %b %b %b %b",
                 i, obs_pc, obs_next, obs_en, obs_fv, obs_req, obs_to,
                 exp_pc, exp_next, exp_en, exp_fv, exp_req, exp_to);
      end
    end
  endtask

  initial begin
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Stall = 1'b0; bus.IC_Ready = 1'b0;
    reset_model();
    test_reset();
    test_miss_then_hit();
    test_redirect_in_miss();
    test_stall_vs_redirect();
    test_wrap();
    test_random();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage controller that owns the program counter register and sequences it against the instruction cache handshake. It advances the PC by 4 on each accepted fetch and holds it on a cache miss or pipeline stall. It applies branch/jump redirects, including redirects that arrive while a miss is outstanding. It sits between the PC register, the I-cache front port, and the decode/hazard unit.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 255, miss cycles before the sticky timeout flag sets (8-bit counter, 1..255)

- CLK  in  1  rising-edge clock
- RST  in  1  reset, asynchronous, active-high
- Redirect  in  1  branch/jump taken this cycle
- RedirectPC  in  XLEN  redirect target; bits [1:0] forced to 0 internally
- Stall  in  1  hazard stall from the decode/hazard unit; hold the PC
- IC_Ready  in  1  I-cache returns the instruction for PC this cycle
- IC_Req  out  1  fetch request for address PC
- PC  out  XLEN  current fetch address (registered)
- PCNext  out  XLEN  value PC takes at the next edge when PCEn=1 (combinational)
- PCEn  out  1  PC load enable this cycle
- FetchValid  out  1  the returned instruction is valid, not squashed
- Timeout  out  1  sticky; miss exceeded TIMEOUT cycles

## Operation
- States: BOOT, FETCH, MISS. Reset sets BOOT and clears `pend`, `pend_pc`, `cnt` and Timeout.
- BOOT (one cycle): IC_Req=0, PCEn=0, FetchValid=0. Unconditionally goes to FETCH; a Redirect in BOOT is ignored.
- FETCH: IC_Req=1. Decisions in priority order:
  - Redirect=1: PCNext=RedirectPC&~3, PCEn=1, FetchValid=0, stay in FETCH. This applies regardless of IC_Ready or Stall.
  - IC_Ready=1, Stall=0: PCNext=PC+4, PCEn=1, FetchValid=1.
  - IC_Ready=1, Stall=1: PCEn=0, FetchValid=1. The same instruction is presented again next cycle.
  - IC_Ready=0: PCEn=0, FetchValid=0, go to MISS, cnt<=1.
- MISS: IC_Req=1 and the PC is held. The in-flight request is never abandoned.
  - Redirect=1: pend<=1, pend_pc<=RedirectPC&~3. If several redirects arrive, the last one wins.
  - cnt increments and saturates at TIMEOUT. When cnt reaches TIMEOUT, Timeout<=1 and stays set until RST.
  - IC_Ready=1 with pend=1, or with Redirect in the same cycle: PCNext=that target (a same-cycle Redirect wins over pend_pc), PCEn=1, FetchValid=0, pend<=0. This ignores Stall.
  - IC_Ready=1 with no pending redirect: same rules as FETCH (advance, or hold if Stall), FetchValid=1.
  - In every IC_Ready=1 case: go to FETCH, cnt<=0.
- Arithmetic: PC+4 is modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- When PCEn=0, PCNext=PC.

## Timing
- Reset values: PC=RESET_PC, IC_Req=0, PCEn=0, FetchValid=0, Timeout=0.
- IC_Req rises in the cycle after reset release, when BOOT moves to FETCH.
- PC updates on the rising CLK edge where PCEn=1, so the new PC is visible in the following cycle.
- Hit path: zero-wait. One instruction per cycle when IC_Ready=1 continuously and Stall=0.
- Miss path: PC is held for N cycles of IC_Ready=0, then advances on the IC_Ready cycle.
- Redirect-to-new-PC latency:
  - 1 edge in FETCH.
  - In MISS: the edge of the IC_Ready cycle.
- RST asserted mid-MISS aborts the miss immediately (async reset). Pending redirect and cnt are cleared.

## Structure
- Shared package `fetch_pkg`:
  - state enum {BOOT, FETCH, MISS}
  - INSTR_BYTES=4
  - RESET_PC default
  - TIMEOUT_W=8
- Sub-module `pc_reg`: XLEN-bit register with load enable and async active-high reset to RESET_PC, driven by PCNext/PCEn.
- FSM, cnt and pending-redirect logic live in `fetch_pc_ctrl`.

## Test plan
- Reset/boot: hold RST=1 for 3 cycles, then release.
  - During reset: PC=0, IC_Req=0.
  - Cycle after release: IC_Req=1.
  - With IC_Ready=1 continuously: PC steps 0,4,8,12.
- Miss, then hit:
  - At PC=8, drop IC_Ready for 3 cycles: PC held at 8, FetchValid=0, state MISS.
  - IC_Ready returns: FetchValid=1 and PC becomes 12 next cycle.
- Redirect during miss:
  - At PC=16 in MISS, pulse Redirect with RedirectPC=0x103, then pulse again with 0x200.
  - On IC_Ready: FetchValid=0 and PC becomes 0x200 (last redirect wins; bits [1:0] cleared).
- Stall versus redirect:
  - At PC=0x20 with IC_Ready=1 and Stall=1: PC held and FetchValid=1 every cycle.
  - Assert Redirect with RedirectPC=0x40 while Stall=1: PC becomes 0x40 next cycle.
- Timeout and wrap:
  - Hold IC_Ready=0 for 255 cycles: Timeout=1 and stays 1 after IC_Ready returns.
  - Separately, redirect to 0xFFFF_FFFC and take a hit: PC wraps to 0x0.
- Async reset mid-miss:
  - Assert RST in cycle 2 of a miss: PC=RESET_PC, IC_Req=0 and Timeout=0 immediately, with no clock edge.
